// File: rtl/mem_arbiter.sv
// Two-client round-robin arbiter in front of a single in-order memory port.
// Response ownership is tracked by a tag FIFO so replies return to the right client.
module mem_arbiter #(
  parameter int DEPTH = 4
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       c0_req_valid,
  input  logic                       c1_req_valid,
  input  logic [67:0]                c0_req,
  input  logic [67:0]                c1_req,
  output logic                       c0_req_ready,
  output logic                       c1_req_ready,
  output logic                       c0_resp_valid,
  output logic                       c1_resp_valid,
  input  logic                       c0_resp_ready,
  input  logic                       c1_resp_ready,
  output logic [67:0]                c_resp,
  output logic                       mem_put_valid,
  input  logic                       mem_put_ready,
  output logic [67:0]                mem_put_request,
  output logic                       mem_get_valid,
  input  logic                       mem_get_ready,
  input  logic [67:0]                mem_get_response,
  output logic [$clog2(DEPTH):0]     outstanding,
  output logic                       err_orphan
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DepthC = CW'(DEPTH);

  logic          tags_q [DEPTH];
  logic [PW-1:0] wrPtr_q, wrPtr_d;
  logic [PW-1:0] rdPtr_q, rdPtr_d;
  logic [CW-1:0] count_q, count_d;
  logic          lastGrant_q, lastGrant_d;
  logic          err_q, err_d;

  logic grant1, notFull, empty, head, push, pop, active;

  always_comb begin
    active  = !RST;
    notFull = count_q < DepthC;
    empty   = count_q == '0;
    head    = tags_q[rdPtr_q];

    // On a tie, hand the port to whichever client did not win last time.
    if (c0_req_valid && c1_req_valid) grant1 = !lastGrant_q;
    else                              grant1 = c1_req_valid;

    c0_req_ready    = active && c0_req_valid && !grant1 && mem_put_ready && notFull;
    c1_req_ready    = active && c1_req_valid &&  grant1 && mem_put_ready && notFull;
    push            = c0_req_ready || c1_req_ready;
    mem_put_valid   = push;
    mem_put_request = grant1 ? c1_req : c0_req;

    // Only the head-tag client may see a response; the other waits behind it.
    c0_resp_valid = active && !empty && mem_get_ready && !head;
    c1_resp_valid = active && !empty && mem_get_ready &&  head;
    pop           = active && !empty && mem_get_ready &&
                    (head ? c1_resp_ready : c0_resp_ready);
    mem_get_valid = pop;
    c_resp        = mem_get_response;

    wrPtr_d     = push ? wrPtr_q + PW'(1) : wrPtr_q;
    rdPtr_d     = pop  ? rdPtr_q + PW'(1) : rdPtr_q;
    count_d     = count_q + CW'(push) - CW'(pop);
    lastGrant_d = push ? grant1 : lastGrant_q;
    err_d       = err_q || (mem_get_ready && empty);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wrPtr_q     <= '0;
      rdPtr_q     <= '0;
      count_q     <= '0;
      lastGrant_q <= 1'b1;
      err_q       <= 1'b0;
    end else begin
      wrPtr_q     <= wrPtr_d;
      rdPtr_q     <= rdPtr_d;
      count_q     <= count_d;
      lastGrant_q <= lastGrant_d;
      err_q       <= err_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (push) tags_q[wrPtr_q] <= grant1;
  end

  assign outstanding = count_q;
  assign err_orphan  = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter; a queue of owner ids stands in for the
// tag FIFO and each cycle's outputs are predicted from the arbitration rules.
module tb_mem_arbiter;
  localparam int DEPTH = 4;

  logic        CLK = 1'b0;
  logic        RST;
  logic        c0_req_valid, c1_req_valid;
  logic [67:0] c0_req, c1_req;
  logic        c0_req_ready, c1_req_ready;
  logic        c0_resp_valid, c1_resp_valid;
  logic        c0_resp_ready, c1_resp_ready;
  logic [67:0] c_resp;
  logic        mem_put_valid, mem_put_ready;
  logic [67:0] mem_put_request;
  logic        mem_get_valid, mem_get_ready;
  logic [67:0] mem_get_response;
  logic [2:0]  outstanding;
  logic        err_orphan;

  always #5 CLK = ~CLK;

  mem_arbiter #(.DEPTH(DEPTH)) dut (
    .CLK(CLK), .RST(RST),
    .c0_req_valid(c0_req_valid), .c1_req_valid(c1_req_valid),
    .c0_req(c0_req), .c1_req(c1_req),
    .c0_req_ready(c0_req_ready), .c1_req_ready(c1_req_ready),
    .c0_resp_valid(c0_resp_valid), .c1_resp_valid(c1_resp_valid),
    .c0_resp_ready(c0_resp_ready), .c1_resp_ready(c1_resp_ready),
    .c_resp(c_resp),
    .mem_put_valid(mem_put_valid), .mem_put_ready(mem_put_ready),
    .mem_put_request(mem_put_request),
    .mem_get_valid(mem_get_valid), .mem_get_ready(mem_get_ready),
    .mem_get_response(mem_get_response),
    .outstanding(outstanding), .err_orphan(err_orphan)
  );

  int vecCount  = 0;
  int missCount = 0;

  // Reference state: who owns each in-flight request, oldest first.
  int ownerQ[$];
  int lastGrant = 1;
  bit errModel  = 1'b0;

  task automatic checkOutput(input string tag, input logic [67:0] obs, input logic [67:0] exp);
    vecCount++;
    if (obs !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input bit rst, input bit v0, input bit v1, input bit putRdy,
                               input bit getRdy, input bit r0, input bit r1);
    int  gnt;
    int  size;
    bit  expRdy0, expRdy1, expPush, expPop;
    bit  expRv0, expRv1;
    logic [67:0] expReq;
    @(negedge CLK);
    RST              = rst;
    c0_req_valid     = v0;
    c1_req_valid     = v1;
    mem_put_ready    = putRdy;
    mem_get_ready    = getRdy;
    c0_resp_ready    = r0;
    c1_resp_ready    = r1;
    c0_req           = {4'($urandom), $urandom, $urandom};
    c1_req           = {4'($urandom), $urandom, $urandom};
    mem_get_response = {4'($urandom), $urandom, $urandom};
    #1;
    size = ownerQ.size();
    checkOutput("outstanding", 68'(outstanding), 68'(size));
    checkOutput("err_orphan", 68'(err_orphan), 68'(errModel));

    if (v0 && v1)  gnt = 1 - lastGrant;
    else if (v1)   gnt = 1;
    else if (v0)   gnt = 0;
    else           gnt = -1;
    expRdy0 = !rst && gnt == 0 && putRdy && size < DEPTH;
    expRdy1 = !rst && gnt == 1 && putRdy && size < DEPTH;
    expPush = expRdy0 || expRdy1;
    expRv0  = !rst && getRdy && size > 0 && ownerQ[0] == 0;
    expRv1  = !rst && getRdy && size > 0 && ownerQ[0] == 1;
    expPop  = (expRv0 && r0) || (expRv1 && r1);
    expReq  = (gnt == 1) ? c1_req : c0_req;

    checkOutput("c0_req_ready", 68'(c0_req_ready), 68'(expRdy0));
    checkOutput("c1_req_ready", 68'(c1_req_ready), 68'(expRdy1));
    checkOutput("mem_put_valid", 68'(mem_put_valid), 68'(expPush));
    if (expPush) checkOutput("mem_put_request", mem_put_request, expReq);
    checkOutput("c0_resp_valid", 68'(c0_resp_valid), 68'(expRv0));
    checkOutput("c1_resp_valid", 68'(c1_resp_valid), 68'(expRv1));
    checkOutput("mem_get_valid", 68'(mem_get_valid), 68'(expPop));
    if (expRv0 || expRv1) checkOutput("c_resp", c_resp, mem_get_response);

    if (rst) begin
      ownerQ.delete();
      lastGrant = 1;
      errModel  = 1'b0;
    end else begin
      if (getRdy && size == 0) errModel = 1'b1;
      if (expPop) void'(ownerQ.pop_front());
      if (expPush) begin
        ownerQ.push_back(gnt);
        lastGrant = gnt;
      end
    end
  endtask

  initial begin
    int pV, pPut, pGet, pRdy;
    RST = 1'b1;
    c0_req_valid = 0; c1_req_valid = 0; c0_req = '0; c1_req = '0;
    c0_resp_ready = 0; c1_resp_ready = 0;
    mem_put_ready = 0; mem_get_ready = 0; mem_get_response = '0;

    // Reset, then both clients contend continuously with memory returning.
    applyStimulus(1, 1, 1, 1, 1, 1, 1);
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 1, 1, 0, 1, 1);
    for (int i = 0; i < 8; i++) applyStimulus(0, 1, 1, 1, 1, 1, 1);

    // Fill to DEPTH from c1, free one slot, then accept again.
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) applyStimulus(0, 0, 1, 1, 0, 1, 1);
    applyStimulus(0, 0, 1, 1, 1, 1, 1);
    applyStimulus(0, 0, 1, 1, 0, 1, 1);
    applyStimulus(0, 0, 1, 1, 0, 1, 1);

    // Head owned by c0 and stalled: c1's response must wait behind it.
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 1, 1, 0, 1, 1);
    applyStimulus(0, 1, 1, 1, 0, 1, 1);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 1, 1, 0, 1);
    applyStimulus(0, 0, 0, 1, 1, 1, 1);
    applyStimulus(0, 1, 0, 1, 1, 1, 1);
    applyStimulus(0, 0, 0, 1, 0, 1, 1);

    // Orphan response sets a sticky error that only reset clears.
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 1, 1);
    for (int i = 0; i < 3; i++) applyStimulus(0, 1, 0, 1, 0, 1, 1);
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 1, 1, 0, 1, 1);
    applyStimulus(0, 1, 1, 1, 0, 1, 1);

    for (int blk = 0; blk < 30; blk++) begin
      pV   = $urandom_range(20, 95);
      pPut = $urandom_range(20, 100);
      pGet = $urandom_range(10, 95);
      pRdy = $urandom_range(20, 100);
      for (int i = 0; i < 100; i++)
        applyStimulus($urandom_range(0, 99) < 2,
                      $urandom_range(0, 99) < pV, $urandom_range(0, 99) < pV,
                      $urandom_range(0, 99) < pPut, $urandom_range(0, 99) < pGet,
                      $urandom_range(0, 99) < pRdy, $urandom_range(0, 99) < pRdy);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
